mpd_prj_switch: RTL and testbench



---
 rtl/mpd_pkg.sv | 11 +
 rtl/mpd_sync2.sv | 21 ++
 rtl/mpd_prj_switch.sv | 131 +++++++++++++
 tb/tb_mpd_prj_switch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpd_pkg.sv
// Shared definitions for the project switch: handover state encoding and switch counter width.
package mpd_pkg;

    localparam logic [1:0] MPD_SW_RUN     = 2'd0;
    localparam logic [1:0] MPD_SW_QUIESCE = 2'd1;
    localparam logic [1:0] MPD_SW_HOLD    = 2'd2;
    localparam logic [1:0] MPD_SW_RELEASE = 2'd3;

    localparam int MPD_SW_CNT_W = 8;

endpackage

// File: rtl/mpd_sync2.sv
// Generic single-bit two-flop synchroniser, asynchronously reset to 0.
module mpd_sync2 (
    input  logic fabric_clk,
    input  logic resetb,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge fabric_clk or negedge resetb) begin
        if (!resetb) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mpd_prj_switch.sv
// User-project switch: debounced select with quiesce -> reset hold -> release handover.
// Build option MPD_PRJ_SEL_SYNC_EN inserts a 2-flop synchroniser on sel_i.
module mpd_prj_switch
    import mpd_pkg::*;
#(
    parameter int NUM_PRJ       = 4,
    parameter int SEL_W         = 2,
    parameter int DATA_W        = 128,
    parameter int RST_CYCLES    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      fabric_clk,
    input  logic                      resetb,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [NUM_PRJ*DATA_W-1:0] prj_data_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [NUM_PRJ-1:0]        prj_rst_o,
    output logic [SEL_W-1:0]          active_o,
    output logic                      busy_o,
    output logic [MPD_SW_CNT_W-1:0]   switch_cnt_o
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_CYCLES - 1);

    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0]  sel_src;
    logic [SEL_W-1:0]  sel_q;
    logic [STAB_W-1:0] stab_cnt;
    logic [SEL_W-1:0]  pending;
    logic              booting;
    logic              in_range;
    logic              commit;
    logic [NUM_PRJ-1:0] run_rst;
    logic [DATA_W-1:0] slot [2**SEL_W];

`ifdef MPD_PRJ_SEL_SYNC_EN
    logic [SEL_W-1:0] sel_sync;
    for (genvar b = 0; b < SEL_W; b++) begin : g_sync
        mpd_sync2 u_sync (
            .fabric_clk (fabric_clk),
            .resetb     (resetb),
            .d          (sel_i[b]),
            .q          (sel_sync[b])
        );
    end
    assign sel_src = sel_sync;
`else
    assign sel_src = sel_i;
`endif

    // Unpopulated select codes read as zero so the mux never indexes past the bus.
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_slot
        if (k < NUM_PRJ) begin : g_used
            assign slot[k] = prj_data_i[k*DATA_W +: DATA_W];
        end else begin : g_unused
            assign slot[k] = '0;
        end
    end

    assign in_range = ({1'b0, sel_q} < (SEL_W+1)'(NUM_PRJ));
    assign commit   = (state == MPD_SW_RUN) && (sel_q != active_o) && in_range
                      && (stab_cnt == STAB_MAX);
    assign run_rst  = ~(NUM_PRJ'(1) << active_o);
    assign busy_o   = (state != MPD_SW_RUN);

    always_ff @(posedge fabric_clk or negedge resetb) begin
        if (!resetb) begin
            state        <= MPD_SW_HOLD;
            hold_cnt     <= '0;
            sel_q        <= '0;
            stab_cnt     <= '0;
            pending      <= '0;
            booting      <= 1'b1;
            active_o     <= '0;
            prj_rst_o    <= '1;
            data_o       <= '0;
            switch_cnt_o <= '0;
        end else begin
            // Debounce runs in every state so a request made mid-handover is ready in RUN.
            sel_q <= sel_src;
            if (sel_src != sel_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            case (state)
                MPD_SW_RUN: begin
                    data_o    <= slot[active_o];
                    prj_rst_o <= run_rst;
                    if (commit) begin
                        state     <= MPD_SW_QUIESCE;
                        data_o    <= '0;
                        prj_rst_o <= '1;
                        pending   <= sel_q;
                    end
                end
                MPD_SW_QUIESCE: begin
                    data_o    <= '0;
                    prj_rst_o <= '1;
                    active_o  <= pending;
                    hold_cnt  <= '0;
                    state     <= MPD_SW_HOLD;
                end
                MPD_SW_HOLD: begin
                    data_o    <= '0;
                    prj_rst_o <= '1;
                    if (hold_cnt == HOLD_MAX) begin
                        state <= MPD_SW_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    data_o    <= '0;
                    prj_rst_o <= run_rst;
                    state     <= MPD_SW_RUN;
                    booting   <= 1'b0;
                    if (!booting && (switch_cnt_o != '1)) begin
                        switch_cnt_o <= switch_cnt_o + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpd_prj_switch.sv
// Directed bench for mpd_prj_switch: boot, switch, glitch reject, back-to-back, async reset, saturation.
module tb_mpd_prj_switch;

    localparam int NUM_PRJ = 4;
    localparam int SEL_W   = 2;
    localparam int DATA_W  = 128;

    localparam logic [DATA_W-1:0] S0 = 128'hA5;
    localparam logic [DATA_W-1:0] S1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [DATA_W-1:0] S2 = 128'hC3C3_0000_0000_0000_0000_0000_0000_00C3;
    localparam logic [DATA_W-1:0] S3 = 128'h3C00_0000_0000_0000_0000_0000_0000_003C;

    logic                      fabric_clk = 1'b0;
    logic                      resetb;
    logic [SEL_W-1:0]          sel_i;
    logic [NUM_PRJ*DATA_W-1:0] prj_data_i;
    logic [DATA_W-1:0]         data_o;
    logic [NUM_PRJ-1:0]        prj_rst_o;
    logic [SEL_W-1:0]          active_o;
    logic                      busy_o;
    logic [7:0]                switch_cnt_o;

    int checks = 0;
    int errors = 0;

    mpd_prj_switch #(
        .NUM_PRJ(NUM_PRJ), .SEL_W(SEL_W), .DATA_W(DATA_W),
        .RST_CYCLES(8), .STABLE_CYCLES(4)
    ) dut (
        .fabric_clk   (fabric_clk),
        .resetb       (resetb),
        .sel_i        (sel_i),
        .prj_data_i   (prj_data_i),
        .data_o       (data_o),
        .prj_rst_o    (prj_rst_o),
        .active_o     (active_o),
        .busy_o       (busy_o),
        .switch_cnt_o (switch_cnt_o)
    );

    always #5 fabric_clk = ~fabric_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge fabric_clk);
    endtask

    task automatic test_reset;
        resetb     = 1'b0;
        sel_i      = '0;
        prj_data_i = {S3, S2, S1, S0};
        tick(2);
        checks++;
        if ({prj_rst_o, busy_o, active_o, switch_cnt_o} !== {4'b1111, 1'b1, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_ctrl rst=%b busy=%b act=%0d cnt=%0d required rst=1111 busy=1 act=0 cnt=0",
                     prj_rst_o, busy_o, active_o, switch_cnt_o);
        end
        checks++;
        if (data_o !== '0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", data_o);
        end
    endtask

    // Called with resetb low at a negedge; releases it and checks the boot handover.
    task automatic test_boot(input string tag);
        resetb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            checks++;
            if ({prj_rst_o, busy_o, data_o} !== {4'b1111, 1'b1, 128'h0}) begin
                errors++;
                $display("FAIL %s_hold cycle %0d rst=%b busy=%b data=%h required rst=1111 busy=1 data=0",
                         tag, i, prj_rst_o, busy_o, data_o);
            end
        end
        tick(1);
        checks++;
        if ({prj_rst_o, busy_o, active_o, data_o} !== {4'b1110, 1'b0, 2'd0, 128'h0}) begin
            errors++;
            $display("FAIL %s_release rst=%b busy=%b act=%0d data=%h required rst=1110 busy=0 act=0 data=0",
                     tag, prj_rst_o, busy_o, active_o, data_o);
        end
        tick(1);
        checks++;
        if ({data_o, switch_cnt_o} !== {S0, 8'd0}) begin
            errors++;
            $display("FAIL %s_data data=%h cnt=%0d required data=%h cnt=0", tag, data_o, switch_cnt_o, S0);
        end
    endtask

    task automatic test_glitch;
        sel_i = 2'd3;
        tick(3);
        sel_i = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if ({busy_o, prj_rst_o, active_o, data_o} !== {1'b0, 4'b1110, 2'd0, S0}) begin
                errors++;
                $display("FAIL glitch cycle %0d busy=%b rst=%b act=%0d data=%h required busy=0 rst=1110 act=0 data=%h",
                         i, busy_o, prj_rst_o, active_o, data_o, S0);
            end
        end
    endtask

    task automatic test_switch;
        sel_i = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if ({busy_o, prj_rst_o, data_o} !== {1'b0, 4'b1110, S0}) begin
                errors++;
                $display("FAIL switch_precommit cycle %0d busy=%b rst=%b data=%h required busy=0 rst=1110 data=%h",
                         i, busy_o, prj_rst_o, data_o, S0);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if ({busy_o, prj_rst_o, data_o} !== {1'b1, 4'b1111, 128'h0}) begin
                errors++;
                $display("FAIL switch_handover cycle %0d busy=%b rst=%b data=%h required busy=1 rst=1111 data=0",
                         i, busy_o, prj_rst_o, data_o);
            end
        end
        tick(1);
        checks++;
        if ({busy_o, prj_rst_o, active_o, switch_cnt_o, data_o} !== {1'b0, 4'b1011, 2'd2, 8'd1, 128'h0}) begin
            errors++;
            $display("FAIL switch_run busy=%b rst=%b act=%0d cnt=%0d data=%h required busy=0 rst=1011 act=2 cnt=1 data=0",
                     busy_o, prj_rst_o, active_o, switch_cnt_o, data_o);
        end
        tick(1);
        checks++;
        if (data_o !== S2) begin
            errors++;
            $display("FAIL switch_data got %h required %h", data_o, S2);
        end
    endtask

    task automatic test_back_to_back;
        sel_i = 2'd1;
        tick(6);
        checks++;
        if ({busy_o, active_o} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL b2b_hold busy=%b act=%0d required busy=1 act=1", busy_o, active_o);
        end
        sel_i = 2'd3;
        tick(9);
        checks++;
        if ({busy_o, prj_rst_o, active_o, switch_cnt_o} !== {1'b0, 4'b1101, 2'd1, 8'd2}) begin
            errors++;
            $display("FAIL b2b_land busy=%b rst=%b act=%0d cnt=%0d required busy=0 rst=1101 act=1 cnt=2",
                     busy_o, prj_rst_o, active_o, switch_cnt_o);
        end
        tick(1);
        checks++;
        if ({busy_o, prj_rst_o, data_o} !== {1'b1, 4'b1111, 128'h0}) begin
            errors++;
            $display("FAIL b2b_second busy=%b rst=%b data=%h required busy=1 rst=1111 data=0",
                     busy_o, prj_rst_o, data_o);
        end
        tick(10);
        checks++;
        if ({busy_o, prj_rst_o, active_o, switch_cnt_o} !== {1'b0, 4'b0111, 2'd3, 8'd3}) begin
            errors++;
            $display("FAIL b2b_final busy=%b rst=%b act=%0d cnt=%0d required busy=0 rst=0111 act=3 cnt=3",
                     busy_o, prj_rst_o, active_o, switch_cnt_o);
        end
        tick(1);
        checks++;
        if (data_o !== S3) begin
            errors++;
            $display("FAIL b2b_data got %h required %h", data_o, S3);
        end
    endtask

    task automatic test_async_reset;
        sel_i = 2'd0;
        tick(16);
        checks++;
        if ({active_o, switch_cnt_o, prj_rst_o, data_o} !== {2'd0, 8'd4, 4'b1110, S0}) begin
            errors++;
            $display("FAIL areset_pre act=%0d cnt=%0d rst=%b data=%h required act=0 cnt=4 rst=1110 data=%h",
                     active_o, switch_cnt_o, prj_rst_o, data_o, S0);
        end
        sel_i = 2'd2;
        tick(8);
        checks++;
        if ({busy_o, active_o} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL areset_inhold busy=%b act=%0d required busy=1 act=2", busy_o, active_o);
        end
        resetb = 1'b0;
        sel_i  = 2'd0;
        #1;
        checks++;
        if ({active_o, switch_cnt_o, prj_rst_o, busy_o, data_o} !== {2'd0, 8'd0, 4'b1111, 1'b1, 128'h0}) begin
            errors++;
            $display("FAIL areset_now act=%0d cnt=%0d rst=%b busy=%b data=%h required act=0 cnt=0 rst=1111 busy=1 data=0",
                     active_o, switch_cnt_o, prj_rst_o, busy_o, data_o);
        end
        tick(1);
        test_boot("reboot");
    endtask

    task automatic test_saturation;
        for (int i = 1; i <= 260; i++) begin
            sel_i = (i % 2 == 1) ? 2'd1 : 2'd0;
            tick(16);
            if (i == 254 || i == 255 || i == 260) begin
                checks++;
                if (switch_cnt_o !== ((i >= 255) ? 8'hFF : 8'(i))) begin
                    errors++;
                    $display("FAIL sat_count after %0d switches got %0d required %0d",
                             i, switch_cnt_o, (i >= 255) ? 255 : i);
                end
            end
        end
        checks++;
        if ({active_o, prj_rst_o, busy_o, data_o} !== {2'd0, 4'b1110, 1'b0, S0}) begin
            errors++;
            $display("FAIL sat_final act=%0d rst=%b busy=%b data=%h required act=0 rst=1110 busy=0 data=%h",
                     active_o, prj_rst_o, busy_o, data_o, S0);
        end
    endtask

    initial begin
        test_reset();
        test_boot("boot");
        test_glitch();
        test_switch();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
